cla_mult_seq: RTL



---
 rtl/cla_mult_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cla_mult_seq.sv
// cla_mult_seq: sequential unsigned shift-and-add multiplier for the calculator
// datapath. A single N+1-bit carry-lookahead adder is reused over N iterations
// to build a 2N-bit product behind a start/busy/done handshake.
//
// Optional feature macro: CLA_MULT_EARLY_TERM_EN
//   When defined, a RUN cycle whose remaining multiplier bits are all zero
//   aligns the accumulator in one shift and finishes early.
//   When undefined, every operation takes N RUN cycles plus the DONE cycle.
module cla_mult_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N:0]       acc_hi_q, acc_hi_d;
  logic [N-1:0]     acc_lo_q, acc_lo_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2*N-1:0]   product_q, product_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [N:0]       addend;
  logic [N:0]       sum;
  logic [2*N:0]     shifted;

`ifdef CLA_MULT_EARLY_TERM_EN
  logic [CW-1:0]    remaining;
  logic [N-1:0]     unconsumed;
  logic [2*N:0]     aligned;
`endif

  // Carry-lookahead adder with carry-in tied to zero. Carries are resolved
  // with full lookahead inside 4-bit groups; each group takes the carry out of
  // the group below it.
  function automatic logic [N:0] cla_add(input logic [N:0] x, input logic [N:0] y);
    logic [N:0] g;
    logic [N:0] p;
    logic [N:0] c;
    logic       pp;
    int         gs;
    g = x & y;
    p = x ^ y;
    c = '0;
    for (int i = 0; i < N; i++) begin
      gs = (i / 4) * 4;
      c[i+1] = g[i];
      pp = p[i];
      for (int j = i - 1; j >= gs; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & c[gs]);
    end
    return p ^ c;
  endfunction

  // Next-state, datapath step and registered-output decode for the multiplier.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    count_d   = count_q;
    product_d = product_q;

    addend  = acc_lo_q[0] ? {1'b0, mcand_q} : '0;
    sum     = cla_add(acc_hi_q, addend);
    shifted = {sum, acc_lo_q} >> 1;

`ifdef CLA_MULT_EARLY_TERM_EN
    remaining  = CW'(N) - count_q;
    unconsumed = acc_lo_q << count_q;
    aligned    = {acc_hi_q, acc_lo_q} >> remaining;
`endif

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          mcand_d  = a;
          acc_lo_d = b;
          acc_hi_d = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        {acc_hi_d, acc_lo_d} = shifted;
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          product_d = shifted[2*N-1:0];
          state_d   = DONE;
        end
`ifdef CLA_MULT_EARLY_TERM_EN
        if (unconsumed == '0) begin
          {acc_hi_d, acc_lo_d} = aligned;
          product_d = aligned[2*N-1:0];
          state_d   = DONE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
